int_wb_arb: RTL and testbench

//  Writeback arbiter at the result end of the dual integer ALU pipes.

---
 rtl/int_wb_arb.sv | 130 +++++++++++++
 tb/tb_int_wb_arb.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_wb_arb.sv
// Writeback arbiter: queues results from two unstallable ALU pipes in per-pipe FIFOs
// and round-robins them onto one registered CDB port.
module int_wb_arb #(
  parameter int DEPTH  = 4,
  parameter int XLEN   = 64,
  parameter int PREG_W = 7,
  parameter int ROB_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid0_i,
  input  logic [XLEN-1:0]   result_0_i,
  input  logic [PREG_W-1:0] dest_phys_0_i,
  input  logic [ROB_W-1:0]  rob_idx_0_i,
  input  logic              valid1_i,
  input  logic [XLEN-1:0]   result_1_i,
  input  logic [PREG_W-1:0] dest_phys_1_i,
  input  logic [ROB_W-1:0]  rob_idx_1_i,
  input  logic              flush_i,
  input  logic              cdb_ready_i,
  output logic              cdb_valid_o,
  output logic [XLEN-1:0]   cdb_result_o,
  output logic [PREG_W-1:0] cdb_dest_phys_o,
  output logic [ROB_W-1:0]  cdb_rob_idx_o,
  output logic              cdb_src_o,
  output logic              stall0_o,
  output logic              stall1_o,
  output logic              overflow_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = XLEN + PREG_W + ROB_W;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - 1);

  logic [PW-1:0] mem [2][DEPTH];
  logic [AW-1:0] wr_ptr [2];
  logic [AW-1:0] rd_ptr [2];
  logic [CW-1:0] count [2];
  logic [PW-1:0] in_pay [2];
  logic [PW-1:0] head [2];
  logic [1:0]    in_valid, non_empty, full, pop, push, drop;
  logic          ld, rr_ptr;

  assign in_valid  = {valid1_i, valid0_i};
  assign in_pay[0] = {result_0_i, dest_phys_0_i, rob_idx_0_i};
  assign in_pay[1] = {result_1_i, dest_phys_1_i, rob_idx_1_i};
  assign non_empty = {count[1] != '0, count[0] != '0};
  assign full      = {count[1] == FULL_CNT, count[0] == FULL_CNT};
  assign head[0]   = mem[0][rd_ptr[0]];
  assign head[1]   = mem[1][rd_ptr[1]];

  // cdb_* is offered while cdb_valid_o=1 and transfers on a cycle with cdb_ready_i=1;
  // until then it holds stable. The register reloads whenever it is empty or draining.
  assign ld = !cdb_valid_o || cdb_ready_i;

  always_comb begin
    pop = 2'b00;
    if (ld && !flush_i) begin
      if (non_empty[0] && (!non_empty[1] || !rr_ptr)) pop = 2'b01;
      else if (non_empty[1])                           pop = 2'b10;
    end
  end

  // A full FIFO still takes a push when it is popped in the same cycle.
  assign push = in_valid & ~{2{flush_i}} & (~full | pop);
  assign drop = in_valid & ~{2{flush_i}} & full & ~pop;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (push[i]) mem[i][wr_ptr[i]] <= in_pay[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else if (flush_i) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid_o     <= 1'b0;
      cdb_result_o    <= '0;
      cdb_dest_phys_o <= '0;
      cdb_rob_idx_o   <= '0;
      cdb_src_o       <= 1'b0;
      rr_ptr          <= 1'b0;
    end else if (flush_i) begin
      cdb_valid_o <= 1'b0;
      rr_ptr      <= 1'b0;
    end else if (pop[0]) begin
      {cdb_result_o, cdb_dest_phys_o, cdb_rob_idx_o} <= head[0];
      cdb_valid_o <= 1'b1;
      cdb_src_o   <= 1'b0;
      rr_ptr      <= 1'b1;
    end else if (pop[1]) begin
      {cdb_result_o, cdb_dest_phys_o, cdb_rob_idx_o} <= head[1];
      cdb_valid_o <= 1'b1;
      cdb_src_o   <= 1'b1;
      rr_ptr      <= 1'b0;
    end else if (ld) begin
      cdb_valid_o <= 1'b0;
    end
  end

  // Sticky until reset; a flush does not clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     overflow_o <= 1'b0;
    else if (|drop) overflow_o <= 1'b1;
  end

  assign stall0_o = count[0] >= STALL_CNT;
  assign stall1_o = count[1] >= STALL_CNT;
endmodule

// File: tb/tb_int_wb_arb.sv
// Bench for int_wb_arb: directed scenarios plus randomized traffic, all checked against
// a queue-based reference model of the writeback arbiter.
module tb_int_wb_arb;
  localparam int DEPTH  = 4;
  localparam int XLEN   = 64;
  localparam int PREG_W = 7;
  localparam int ROB_W  = 8;
  localparam int PW     = XLEN + PREG_W + ROB_W;
  localparam int OW     = PW + 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              valid0_i = 1'b0, valid1_i = 1'b0, flush_i = 1'b0, cdb_ready_i = 1'b0;
  logic [XLEN-1:0]   result_0_i = '0, result_1_i = '0;
  logic [PREG_W-1:0] dest_phys_0_i = '0, dest_phys_1_i = '0;
  logic [ROB_W-1:0]  rob_idx_0_i = '0, rob_idx_1_i = '0;
  logic              cdb_valid_o, cdb_src_o, stall0_o, stall1_o, overflow_o;
  logic [XLEN-1:0]   cdb_result_o;
  logic [PREG_W-1:0] cdb_dest_phys_o;
  logic [ROB_W-1:0]  cdb_rob_idx_o;

  int n_checks = 0;
  int n_pass   = 0;

  int_wb_arb #(.DEPTH(DEPTH), .XLEN(XLEN), .PREG_W(PREG_W), .ROB_W(ROB_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid0_i(valid0_i), .result_0_i(result_0_i), .dest_phys_0_i(dest_phys_0_i),
    .rob_idx_0_i(rob_idx_0_i),
    .valid1_i(valid1_i), .result_1_i(result_1_i), .dest_phys_1_i(dest_phys_1_i),
    .rob_idx_1_i(rob_idx_1_i),
    .flush_i(flush_i), .cdb_ready_i(cdb_ready_i),
    .cdb_valid_o(cdb_valid_o), .cdb_result_o(cdb_result_o),
    .cdb_dest_phys_o(cdb_dest_phys_o), .cdb_rob_idx_o(cdb_rob_idx_o),
    .cdb_src_o(cdb_src_o), .stall0_o(stall0_o), .stall1_o(stall1_o),
    .overflow_o(overflow_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  wire [PW-1:0] cdb_pay = {cdb_result_o, cdb_dest_phys_o, cdb_rob_idx_o};
  wire [OW-1:0] dut_vec = {cdb_valid_o, cdb_valid_o ? {cdb_src_o, cdb_pay} : {(PW+1){1'b0}},
                           stall0_o, stall1_o, overflow_o};

  // ---------------- reference model ----------------
  logic [PW-1:0] q0[$];
  logic [PW-1:0] q1[$];
  logic          m_valid, m_src, m_rr, m_ovf;
  logic [PW-1:0] m_pay;
  logic [PW:0]   exp_q[$];

  task automatic model_clear();
    q0.delete(); q1.delete();
    m_valid = 1'b0; m_src = 1'b0; m_rr = 1'b0; m_ovf = 1'b0; m_pay = '0;
  endtask

  task automatic model_update();
    logic ld, p0, p1, full0, full1;
    if (!rst_n) begin
      model_clear();
    end else if (flush_i) begin
      q0.delete(); q1.delete();
      m_valid = 1'b0; m_rr = 1'b0;
    end else begin
      ld = !m_valid || cdb_ready_i;
      full0 = (q0.size() == DEPTH);
      full1 = (q1.size() == DEPTH);
      p0 = ld && q0.size() > 0 && (q1.size() == 0 || m_rr == 1'b0);
      p1 = ld && !p0 && q1.size() > 0;
      if (p0)      begin m_pay = q0.pop_front(); m_valid = 1'b1; m_src = 1'b0; m_rr = 1'b1; end
      else if (p1) begin m_pay = q1.pop_front(); m_valid = 1'b1; m_src = 1'b1; m_rr = 1'b0; end
      else if (ld) m_valid = 1'b0;
      if (valid0_i) begin
        if (full0 && !p0) m_ovf = 1'b1;
        else q0.push_back({result_0_i, dest_phys_0_i, rob_idx_0_i});
      end
      if (valid1_i) begin
        if (full1 && !p1) m_ovf = 1'b1;
        else q1.push_back({result_1_i, dest_phys_1_i, rob_idx_1_i});
      end
    end
  endtask

  function automatic logic [OW-1:0] exp_vec();
    return {m_valid, m_valid ? {m_src, m_pay} : {(PW+1){1'b0}},
            q0.size() >= DEPTH-1, q1.size() >= DEPTH-1, m_ovf};
  endfunction

  // ---------------- driver tasks ----------------
  function automatic logic [PW-1:0] rand_pay();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[PW-1:0];
  endfunction

  task automatic drive0(input logic v, input logic [PW-1:0] p);
    valid0_i = v;
    {result_0_i, dest_phys_0_i, rob_idx_0_i} = p;
  endtask

  task automatic drive1(input logic v, input logic [PW-1:0] p);
    valid1_i = v;
    {result_1_i, dest_phys_1_i, rob_idx_1_i} = p;
  endtask

  // One clock: model advances with the DUT at posedge; outputs are sampled at negedge.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive0(1'b0, '0); drive1(1'b0, '0);
    flush_i = 1'b0; cdb_ready_i = 1'b0;
    exp_q.delete();
    step();
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({cdb_valid_o, cdb_pay, cdb_src_o, stall0_o, stall1_o, overflow_o} !== '0)
      $display("FAIL reset_outputs got %h exp 0",
               {cdb_valid_o, cdb_pay, cdb_src_o, stall0_o, stall1_o, overflow_o});
    else n_pass++;
  endtask

  task automatic test_latency();
    logic [PW-1:0] p;
    apply_reset();
    p = {64'h1234, 7'd5, 8'd9};
    cdb_ready_i = 1'b1;
    drive0(1'b1, p);
    step();
    drive0(1'b0, '0);
    n_checks++;
    if (cdb_valid_o !== 1'b0) $display("FAIL latency_t1 got valid %b exp 0", cdb_valid_o);
    else n_pass++;
    step();
    n_checks++;
    if ({cdb_valid_o, cdb_src_o, cdb_pay} !== {1'b1, 1'b0, p})
      $display("FAIL latency_t2 got %h exp %h", {cdb_valid_o, cdb_src_o, cdb_pay}, {1'b1, 1'b0, p});
    else n_pass++;
    step();
    n_checks++;
    if (cdb_valid_o !== 1'b0) $display("FAIL latency_t3 got valid %b exp 0", cdb_valid_o);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [PW-1:0] a0, a1, b0, b1;
    int first_cyc;
    apply_reset();
    a0 = rand_pay(); a1 = rand_pay(); b0 = rand_pay(); b1 = rand_pay();
    exp_q.push_back({1'b0, a0}); exp_q.push_back({1'b1, b0});
    exp_q.push_back({1'b0, a1}); exp_q.push_back({1'b1, b1});
    cdb_ready_i = 1'b1;
    first_cyc = -1;
    for (int c = 0; c < 9; c++) begin
      drive0(c < 2, (c == 0) ? a0 : a1);
      drive1(c < 2, (c == 0) ? b0 : b1);
      if (cdb_valid_o && cdb_ready_i) begin
        if (first_cyc < 0) first_cyc = c;
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL rr_extra cyc %0d got %h exp none", c, {cdb_src_o, cdb_pay});
        else if ({cdb_src_o, cdb_pay} !== exp_q[0])
          $display("FAIL rr_order cyc %0d got %h exp %h", c, {cdb_src_o, cdb_pay}, exp_q[0]);
        else n_pass++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      step();
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL rr_model cyc %0d got %h exp %h", c, dut_vec, exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (exp_q.size() != 0 || first_cyc != 2)
      $display("FAIL rr_complete got left %0d first %0d exp left 0 first 2", exp_q.size(), first_cyc);
    else n_pass++;
    drive0(1'b0, '0); drive1(1'b0, '0);
  endtask

  task automatic test_backpressure();
    logic [PW-1:0] p, first;
    apply_reset();
    cdb_ready_i = 1'b0;
    first = '0;
    for (int c = 0; c < 7; c++) begin
      p = rand_pay();
      if (c == 0) first = p;
      drive0(c < 5, p);
      if (c < 5) exp_q.push_back({1'b0, p});
      step();
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL bp_model cyc %0d got %h exp %h", c, dut_vec, exp_vec());
      else n_pass++;
      n_checks++;
      if (stall0_o !== (c >= 3)) $display("FAIL bp_stall cyc %0d got %b exp %b", c, stall0_o, c >= 3);
      else n_pass++;
      if (c >= 1) begin
        n_checks++;
        if ({cdb_valid_o, cdb_pay} !== {1'b1, first})
          $display("FAIL bp_hold cyc %0d got %h exp %h", c, {cdb_valid_o, cdb_pay}, {1'b1, first});
        else n_pass++;
      end
    end
    cdb_ready_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (cdb_valid_o && cdb_ready_i) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL bp_extra cyc %0d got %h exp none", c, cdb_pay);
        else if ({cdb_src_o, cdb_pay} !== exp_q[0])
          $display("FAIL bp_drain cyc %0d got %h exp %h", c, {cdb_src_o, cdb_pay}, exp_q[0]);
        else n_pass++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      step();
    end
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL bp_missing got left %0d exp 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_overflow();
    logic [PW-1:0] p;
    apply_reset();
    cdb_ready_i = 1'b0;
    for (int c = 0; c < 7; c++) begin
      p = rand_pay();
      drive0(1'b1, p);
      if (c < 5) exp_q.push_back({1'b0, p});
      step();
    end
    drive0(1'b0, '0);
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if (overflow_o !== 1'b1 || dut_vec !== exp_vec())
        $display("FAIL ovf_set cyc %0d got %h exp %h", c, dut_vec, exp_vec());
      else n_pass++;
    end
    cdb_ready_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (cdb_valid_o && cdb_ready_i) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL ovf_extra cyc %0d got %h exp none", c, cdb_pay);
        else if ({cdb_src_o, cdb_pay} !== exp_q[0])
          $display("FAIL ovf_drain cyc %0d got %h exp %h", c, {cdb_src_o, cdb_pay}, exp_q[0]);
        else n_pass++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      step();
    end
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL ovf_missing got left %0d exp 0", exp_q.size());
    else n_pass++;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    n_checks++;
    if (overflow_o !== 1'b1) $display("FAIL ovf_after_flush got %b exp 1", overflow_o);
    else n_pass++;
  endtask

  task automatic test_flush();
    apply_reset();
    cdb_ready_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive0(1'b1, rand_pay());
      drive1(c < 3, rand_pay());
      step();
    end
    n_checks++;
    if ({cdb_valid_o, stall0_o, stall1_o} !== 3'b111 || dut_vec !== exp_vec())
      $display("FAIL flush_pre got %h exp %h", dut_vec, exp_vec());
    else n_pass++;
    flush_i = 1'b1; cdb_ready_i = 1'b1;
    drive0(1'b1, rand_pay()); drive1(1'b1, rand_pay());
    step();
    flush_i = 1'b0;
    drive0(1'b0, '0); drive1(1'b0, '0);
    n_checks++;
    if ({cdb_valid_o, stall0_o, stall1_o} !== 3'b000)
      $display("FAIL flush_next got %b exp 000", {cdb_valid_o, stall0_o, stall1_o});
    else n_pass++;
    for (int c = 0; c < 8; c++) begin
      step();
      n_checks++;
      if (cdb_valid_o !== 1'b0 || dut_vec !== exp_vec())
        $display("FAIL flush_quiet cyc %0d got %h exp %h", c, dut_vec, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [PW-1:0] p;
    apply_reset();
    cdb_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive0(1'b1, rand_pay()); drive1(1'b1, rand_pay());
      step();
    end
    drive0(1'b0, '0); drive1(1'b0, '0);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({cdb_valid_o, cdb_pay, cdb_src_o, stall0_o, stall1_o, overflow_o} !== '0)
      $display("FAIL rst_mid_async got %h exp 0", {cdb_valid_o, cdb_pay, cdb_src_o, stall0_o, stall1_o});
    else n_pass++;
    step();
    rst_n = 1'b1;
    cdb_ready_i = 1'b1;
    p = rand_pay();
    drive1(1'b1, p);
    step();
    drive1(1'b0, '0);
    n_checks++;
    if (cdb_valid_o !== 1'b0) $display("FAIL rst_mid_t1 got valid %b exp 0", cdb_valid_o);
    else n_pass++;
    step();
    n_checks++;
    if ({cdb_valid_o, cdb_src_o, cdb_pay} !== {1'b1, 1'b1, p})
      $display("FAIL rst_mid_t2 got %h exp %h", {cdb_valid_o, cdb_src_o, cdb_pay}, {1'b1, 1'b1, p});
    else n_pass++;
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      cdb_ready_i = ($urandom_range(0, 3) != 0);
      flush_i     = ($urandom_range(0, 39) == 0);
      drive0(stall0_o ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 1), rand_pay());
      drive1(stall1_o ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 1), rand_pay());
      step();
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL rand_model cyc %0d got %h exp %h", c, dut_vec, exp_vec());
      else n_pass++;
    end
    flush_i = 1'b0;
    drive0(1'b0, '0); drive1(1'b0, '0);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    model_clear();
    test_reset();
    test_latency();
    test_round_robin();
    test_backpressure();
    test_overflow();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
